// File: rtl/reg_rename_stage_if.sv
// Decoder-side, downstream and write-back release signals of the register-rename stage.
// master drives the instruction/release inputs; slave is the rename stage itself.
interface reg_rename_stage_if #(
  parameter int PHYS_WIDTH = 6
);
  logic                  i_valid;
  logic                  o_ready;
  logic [4:0]            i_rs_addr;
  logic [4:0]            i_rt_addr;
  logic                  i_uses_rw;
  logic [4:0]            i_rw_addr;
  logic                  o_valid;
  logic                  i_ds_ready;
  logic [PHYS_WIDTH-1:0] o_rs_phys;
  logic [PHYS_WIDTH-1:0] o_rt_phys;
  logic                  o_uses_rw;
  logic [PHYS_WIDTH-1:0] o_rw_phys;
  logic [PHYS_WIDTH-1:0] o_old_rw_phys;
  logic                  i_free_valid;
  logic [PHYS_WIDTH-1:0] i_free_phys;
  logic [PHYS_WIDTH:0]   o_free_count;
  logic                  o_free_overflow;

  modport master (
    output i_valid, i_rs_addr, i_rt_addr, i_uses_rw, i_rw_addr, i_ds_ready,
           i_free_valid, i_free_phys,
    input  o_ready, o_valid, o_rs_phys, o_rt_phys, o_uses_rw, o_rw_phys,
           o_old_rw_phys, o_free_count, o_free_overflow
  );

  modport slave (
    input  i_valid, i_rs_addr, i_rt_addr, i_uses_rw, i_rw_addr, i_ds_ready,
           i_free_valid, i_free_phys,
    output o_ready, o_valid, o_rs_phys, o_rt_phys, o_uses_rw, o_rw_phys,
           o_old_rw_phys, o_free_count, o_free_overflow
  );
endinterface

// File: rtl/reg_rename_stage.sv
// Register-rename stage: map table + circular free list, registered renamed output.
// Optional macro REN_FREE_BYPASS_EN hands a release straight to an allocation when the list is empty.
module reg_rename_stage #(
  parameter int ARCH_REGS  = 32,
  parameter int PHYS_REGS  = 64,
  parameter int PHYS_WIDTH = 6,
  parameter int FREE_DEPTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  reg_rename_stage_if.slave  ren
);

  localparam int                  PTR_W      = (FREE_DEPTH > 1) ? $clog2(FREE_DEPTH) : 1;
  localparam logic [PHYS_WIDTH:0] FULL_COUNT = (PHYS_WIDTH + 1)'(FREE_DEPTH);
  localparam logic [PTR_W-1:0]    LAST_PTR   = PTR_W'(FREE_DEPTH - 1);

  logic [PHYS_WIDTH-1:0] map_reg  [ARCH_REGS];
  logic [PHYS_WIDTH-1:0] free_reg [FREE_DEPTH];
  logic [PTR_W-1:0]      head_reg;
  logic [PTR_W-1:0]      tail_reg;
  logic [PHYS_WIDTH:0]   count_reg;
  logic [PHYS_WIDTH:0]   count_next;
  logic                  overflow_reg;

  logic                  valid_reg;
  logic [PHYS_WIDTH-1:0] rs_phys_reg;
  logic [PHYS_WIDTH-1:0] rt_phys_reg;
  logic                  uses_rw_reg;
  logic [PHYS_WIDTH-1:0] rw_phys_reg;
  logic [PHYS_WIDTH-1:0] old_rw_phys_reg;

  logic                  needs_alloc;
  logic                  free_req;
  logic                  list_empty;
  logic                  list_full;
  logic                  bypass_hit;
  logic                  avail;
  logic                  stage_ready;
  logic                  accept;
  logic                  alloc;
  logic                  bypass_take;
  logic                  pop;
  logic                  push;
  logic                  overflow_set;
  logic [PHYS_WIDTH-1:0] alloc_phys;
  logic [PHYS_WIDTH-1:0] old_phys;
  logic [ARCH_REGS-1:0]  map_we;
  logic [FREE_DEPTH-1:0] free_we;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Architectural $0 is hard-wired and never takes a physical register.
  assign needs_alloc = ren.i_uses_rw & (ren.i_rw_addr != 5'd0);
  assign free_req    = ren.i_free_valid & (ren.i_free_phys != '0);
  assign list_empty  = (count_reg == '0);
  assign list_full   = (count_reg == FULL_COUNT);

`ifdef REN_FREE_BYPASS_EN
  assign bypass_hit  = list_empty & free_req;
`else
  assign bypass_hit  = 1'b0;
`endif

  assign avail       = ~list_empty | bypass_hit;
  assign stage_ready = (~valid_reg | ren.i_ds_ready) & (~needs_alloc | avail);
  assign accept      = ren.i_valid & stage_ready;
  assign alloc       = accept & needs_alloc;

  // A bypassed pair consumes the release directly and leaves the list untouched.
  assign bypass_take  = alloc & bypass_hit;
  assign pop          = alloc & ~bypass_take;
  assign push         = free_req & ~bypass_take & (~list_full | pop);
  assign overflow_set = free_req & list_full & ~pop;

  assign alloc_phys = bypass_take ? ren.i_free_phys : free_reg[head_reg];
  assign old_phys   = map_reg[ren.i_rw_addr];

  genvar gi;
  generate
    for (gi = 0; gi < ARCH_REGS; gi++) begin : g_map_we
      assign map_we[gi] = alloc & (ren.i_rw_addr == 5'(gi));
    end
    for (gi = 0; gi < FREE_DEPTH; gi++) begin : g_free_we
      assign free_we[gi] = push & (tail_reg == PTR_W'(gi));
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_reg[i] <= PHYS_WIDTH'(i);
      end
    end else begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        if (map_we[i]) begin
          map_reg[i] <= alloc_phys;
        end
      end
    end
  end

  // Reset image: the registers not covered by the identity map, in ascending order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FREE_DEPTH; i++) begin
        free_reg[i] <= PHYS_WIDTH'(PHYS_REGS - FREE_DEPTH + i);
      end
    end else begin
      for (int i = 0; i < FREE_DEPTH; i++) begin
        if (free_we[i]) begin
          free_reg[i] <= ren.i_free_phys;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= FULL_COUNT;
      overflow_reg <= 1'b0;
    end else begin
      if (pop) begin
        head_reg <= ptr_inc(head_reg);
      end
      if (push) begin
        tail_reg <= ptr_inc(tail_reg);
      end
      count_reg <= count_next;
      if (overflow_set) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Output register holds while downstream stalls; sources read the pre-update map.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg       <= 1'b0;
      rs_phys_reg     <= '0;
      rt_phys_reg     <= '0;
      uses_rw_reg     <= 1'b0;
      rw_phys_reg     <= '0;
      old_rw_phys_reg <= '0;
    end else if (accept) begin
      valid_reg       <= 1'b1;
      rs_phys_reg     <= map_reg[ren.i_rs_addr];
      rt_phys_reg     <= map_reg[ren.i_rt_addr];
      uses_rw_reg     <= ren.i_uses_rw;
      rw_phys_reg     <= alloc ? alloc_phys : '0;
      old_rw_phys_reg <= alloc ? old_phys : '0;
    end else if (ren.i_ds_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign ren.o_ready         = stage_ready;
  assign ren.o_valid         = valid_reg;
  assign ren.o_rs_phys       = rs_phys_reg;
  assign ren.o_rt_phys       = rt_phys_reg;
  assign ren.o_uses_rw       = uses_rw_reg;
  assign ren.o_rw_phys       = rw_phys_reg;
  assign ren.o_old_rw_phys   = old_rw_phys_reg;
  assign ren.o_free_count    = count_reg;
  assign ren.o_free_overflow = overflow_reg;

endmodule

// File: tb/tb_reg_rename_stage.sv
// Self-checking bench for reg_rename_stage: directed vector table, corner-case sequences,
// and randomized traffic checked against a queue/array reference model.
module tb_reg_rename_stage;

  localparam int PW         = 6;
  localparam int ARCH       = 32;
  localparam int FREE_DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_rename_stage_if #(.PHYS_WIDTH(PW)) ren_if ();

  reg_rename_stage #(
    .ARCH_REGS (ARCH),
    .PHYS_REGS (64),
    .PHYS_WIDTH(PW),
    .FREE_DEPTH(FREE_DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ren  (ren_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: architectural map as an array, free list as a FIFO queue.
  int m_map [ARCH];
  int m_free [$];
  bit m_valid;
  int m_rs, m_rt, m_uses, m_rw, m_old;
  bit m_ovf;

  function automatic void model_reset();
    for (int i = 0; i < ARCH; i++) m_map[i] = i;
    m_free.delete();
    for (int i = 0; i < FREE_DEPTH; i++) m_free.push_back(ARCH + i);
    m_valid = 0; m_rs = 0; m_rt = 0; m_uses = 0; m_rw = 0; m_old = 0; m_ovf = 0;
  endfunction

  function automatic bit model_ready();
    bit needs, frel, avail;
    needs = ren_if.i_uses_rw && (ren_if.i_rw_addr != 0);
    frel  = ren_if.i_free_valid && (ren_if.i_free_phys != 0);
    avail = (m_free.size() != 0);
`ifdef REN_FREE_BYPASS_EN
    if (m_free.size() == 0 && frel) avail = 1;
`endif
    return (!m_valid || ren_if.i_ds_ready) && (!needs || avail);
  endfunction

  function automatic void model_clock(input bit ready);
    bit needs, frel, used_bypass;
    int p;
    needs = ren_if.i_uses_rw && (ren_if.i_rw_addr != 0);
    frel  = ren_if.i_free_valid && (ren_if.i_free_phys != 0);
    used_bypass = 0;
    p = 0;
    if (ren_if.i_valid && ready) begin
      m_rs   = m_map[ren_if.i_rs_addr];
      m_rt   = m_map[ren_if.i_rt_addr];
      m_uses = ren_if.i_uses_rw;
      if (needs) begin
        if (m_free.size() != 0) p = m_free.pop_front();
        else begin
          p = ren_if.i_free_phys;
          used_bypass = 1;
        end
        m_old = m_map[ren_if.i_rw_addr];
        m_map[ren_if.i_rw_addr] = p;
        m_rw = p;
      end else begin
        m_rw  = 0;
        m_old = 0;
      end
      m_valid = 1;
    end else if (ren_if.i_ds_ready) begin
      m_valid = 0;
    end
    if (frel && !used_bypass) begin
      if (m_free.size() < FREE_DEPTH) m_free.push_back(int'(ren_if.i_free_phys));
      else m_ovf = 1;
    end
  endfunction

  task automatic drive(input bit v, input int rs, input int rt, input bit uses, input int rw,
                       input bit ds, input bit fv, input int fp);
    ren_if.i_valid      = v;
    ren_if.i_rs_addr    = 5'(rs);
    ren_if.i_rt_addr    = 5'(rt);
    ren_if.i_uses_rw    = uses;
    ren_if.i_rw_addr    = 5'(rw);
    ren_if.i_ds_ready   = ds;
    ren_if.i_free_valid = fv;
    ren_if.i_free_phys  = PW'(fp);
  endtask

  // One clock: drive at posedge+1, sample o_ready at +2, advance model, return at next posedge+1.
  task automatic cycle(input bit v, input int rs, input int rt, input bit uses, input int rw,
                       input bit ds, input bit fv, input int fp,
                       output bit act_ready, output bit exp_ready);
    drive(v, rs, rt, uses, rw, ds, fv, fp);
    #1;
    act_ready = ren_if.o_ready;
    exp_ready = model_ready();
    model_clock(exp_ready);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, int'(ren_if.o_valid), int'(m_valid));
    if (m_valid) begin
      check({tag, "_rs"},   int'(ren_if.o_rs_phys),     m_rs);
      check({tag, "_rt"},   int'(ren_if.o_rt_phys),     m_rt);
      check({tag, "_uses"}, int'(ren_if.o_uses_rw),     m_uses);
      check({tag, "_rw"},   int'(ren_if.o_rw_phys),     m_rw);
      check({tag, "_old"},  int'(ren_if.o_old_rw_phys), m_old);
    end
    check({tag, "_count"}, int'(ren_if.o_free_count), m_free.size());
    check({tag, "_ovf"},   int'(ren_if.o_free_overflow), int'(m_ovf));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, int'(ren_if.o_valid), 0);
    check({tag, "_rs"},    int'(ren_if.o_rs_phys), 0);
    check({tag, "_rt"},    int'(ren_if.o_rt_phys), 0);
    check({tag, "_uses"},  int'(ren_if.o_uses_rw), 0);
    check({tag, "_rw"},    int'(ren_if.o_rw_phys), 0);
    check({tag, "_old"},   int'(ren_if.o_old_rw_phys), 0);
    check({tag, "_count"}, int'(ren_if.o_free_count), FREE_DEPTH);
    check({tag, "_ovf"},   int'(ren_if.o_free_overflow), 0);
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_ready", int'(ren_if.o_ready), 1);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit v; int rs; int rt; bit uses; int rw; bit ds; bit fv; int fp;
    bit e_ready; bit e_valid; int e_rs; int e_rt; int e_rw; int e_old; int e_count;
  } vec_t;

  vec_t vecs [10];
  bit   ar, er;
  bit   held_valid;
  int   held_rs, held_rt, held_rw, held_old;

  initial begin
    // Directed stream after reset: allocations, re-writes, self-source, $0 and zero-release.
    vecs[0] = '{1, 0, 0, 1,  1, 1, 0,  0,  1, 1,  0,  0, 32,  1, 31};
    vecs[1] = '{1, 1, 0, 1,  2, 1, 0,  0,  1, 1, 32,  0, 33,  2, 30};
    vecs[2] = '{1, 2, 1, 1,  3, 1, 0,  0,  1, 1, 33, 32, 34,  3, 29};
    vecs[3] = '{1, 0, 0, 1,  1, 1, 0,  0,  1, 1,  0,  0, 35, 32, 28};
    vecs[4] = '{1, 1, 3, 0,  1, 1, 0,  0,  1, 1, 35, 34,  0,  0, 28};
    vecs[5] = '{1, 5, 0, 1,  5, 1, 0,  0,  1, 1,  5,  0, 36,  5, 27};
    vecs[6] = '{1, 3, 0, 1,  0, 1, 0,  0,  1, 1, 34,  0,  0,  0, 27};
    vecs[7] = '{0, 0, 0, 0,  0, 1, 1,  0,  1, 0,  0,  0,  0,  0, 27};
    vecs[8] = '{0, 0, 0, 0,  0, 1, 1, 32,  1, 0,  0,  0,  0,  0, 28};
    vecs[9] = '{1, 1, 5, 1, 31, 1, 1,  0,  1, 1, 35, 36, 37, 31, 27};

    apply_reset();

    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].uses, vecs[i].rw,
            vecs[i].ds, vecs[i].fv, vecs[i].fp, ar, er);
      check($sformatf("vec%0d_ready", i), int'(ar), int'(vecs[i].e_ready));
      check($sformatf("vec%0d_valid", i), int'(ren_if.o_valid), int'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_rs", i),  int'(ren_if.o_rs_phys),     vecs[i].e_rs);
        check($sformatf("vec%0d_rt", i),  int'(ren_if.o_rt_phys),     vecs[i].e_rt);
        check($sformatf("vec%0d_rw", i),  int'(ren_if.o_rw_phys),     vecs[i].e_rw);
        check($sformatf("vec%0d_old", i), int'(ren_if.o_old_rw_phys), vecs[i].e_old);
      end
      check($sformatf("vec%0d_count", i), int'(ren_if.o_free_count), vecs[i].e_count);
      $display("vec %0d: ready=%0b valid=%0b rs=%0d rt=%0d rw=%0d old=%0d count=%0d", i, ar,
               ren_if.o_valid, ren_if.o_rs_phys, ren_if.o_rt_phys, ren_if.o_rw_phys,
               ren_if.o_old_rw_phys, ren_if.o_free_count);
    end

    // Downstream stall: output holds, nothing accepted, head stays put.
    apply_reset();
    cycle(1, 0, 0, 1, 1, 1, 0, 0, ar, er);
    for (int k = 0; k < 4; k++) begin
      cycle(1, 4, 6, 1, 2, 0, 0, 0, ar, er);
      check("stall_ready", int'(ar), 0);
      check("stall_valid", int'(ren_if.o_valid), 1);
      check("stall_rw",    int'(ren_if.o_rw_phys), 32);
      check("stall_old",   int'(ren_if.o_old_rw_phys), 1);
      check("stall_count", int'(ren_if.o_free_count), 31);
      $display("stall %0d: ready=%0b rw=%0d count=%0d", k, ar, ren_if.o_rw_phys, ren_if.o_free_count);
    end
    cycle(1, 4, 6, 1, 2, 1, 0, 0, ar, er);
    check("unstall_ready", int'(ar), 1);
    check("unstall_rw",    int'(ren_if.o_rw_phys), 33);
    check("unstall_count", int'(ren_if.o_free_count), 30);

    // Exhaust the free list, then stall a destination writer until a release arrives.
    apply_reset();
    for (int k = 0; k < 32; k++) begin
      cycle(1, 0, 0, 1, (k % 31) + 1, 1, 0, 0, ar, er);
      check("exhaust_ready", int'(ar), 1);
      check("exhaust_rw", int'(ren_if.o_rw_phys), 32 + k);
    end
    $display("exhaust: count=%0d", ren_if.o_free_count);
    check("empty_count", int'(ren_if.o_free_count), 0);
    cycle(1, 0, 0, 1, 7, 1, 0, 0, ar, er);
    check("empty_stall_ready", int'(ar), 0);
    check("empty_stall_valid", int'(ren_if.o_valid), 0);
    cycle(1, 0, 0, 1, 7, 1, 1, 7, ar, er);
`ifdef REN_FREE_BYPASS_EN
    check("bypass_ready", int'(ar), 1);
`else
    check("free_same_cycle_ready", int'(ar), 0);
    check("free_arrived_count", int'(ren_if.o_free_count), 1);
    cycle(1, 0, 0, 1, 7, 1, 0, 0, ar, er);
    check("after_free_ready", int'(ar), 1);
`endif
    check("refill_valid", int'(ren_if.o_valid), 1);
    check("refill_rw",    int'(ren_if.o_rw_phys), 7);
    check("refill_old",   int'(ren_if.o_old_rw_phys), 38);
    check("refill_count", int'(ren_if.o_free_count), 0);
    $display("refill: rw=%0d old=%0d count=%0d", ren_if.o_rw_phys, ren_if.o_old_rw_phys,
             ren_if.o_free_count);
    // With the list empty, no-destination instructions still flow.
    cycle(1, 7, 1, 0, 9, 1, 0, 0, ar, er);
    check("empty_passthru_ready", int'(ar), 1);
    check("empty_passthru_rs", int'(ren_if.o_rs_phys), 7);

    // Release at full count: simultaneous allocation absorbs it, a lone one overflows.
    apply_reset();
    cycle(1, 0, 0, 1, 1, 1, 1, 45, ar, er);
    check("full_pair_count", int'(ren_if.o_free_count), 32);
    check("full_pair_ovf",   int'(ren_if.o_free_overflow), 0);
    check("full_pair_rw",    int'(ren_if.o_rw_phys), 32);
    cycle(0, 0, 0, 0, 0, 1, 1, 40, ar, er);
    check("overflow_set",   int'(ren_if.o_free_overflow), 1);
    check("overflow_count", int'(ren_if.o_free_count), 32);
    cycle(0, 0, 0, 0, 0, 1, 0, 0, ar, er);
    check("overflow_sticky", int'(ren_if.o_free_overflow), 1);
    $display("overflow: flag=%0b count=%0d", ren_if.o_free_overflow, ren_if.o_free_count);

    // Randomized traffic against the model, with an asynchronous reset pulse mid-stream.
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1, 5, 9, 0, 0, 1, 0, 0, ar, er);
        check("post_reset_rs", int'(ren_if.o_rs_phys), 5);
        check("post_reset_rt", int'(ren_if.o_rt_phys), 9);
        $display("async reset: rs=%0d rt=%0d count=%0d", ren_if.o_rs_phys, ren_if.o_rt_phys,
                 ren_if.o_free_count);
      end
      cycle(($urandom_range(99) < 70), $urandom_range(31), $urandom_range(31),
            ($urandom_range(99) < 60), $urandom_range(31), ($urandom_range(99) < 75),
            ($urandom_range(99) < 35), $urandom_range(63), ar, er);
      check("rand_ready", int'(ar), int'(er));
      check_model("rand");
      $display("rand %0d: ready=%0b valid=%0b rs=%0d rt=%0d rw=%0d old=%0d count=%0d ovf=%0b",
               n, ar, ren_if.o_valid, ren_if.o_rs_phys, ren_if.o_rt_phys, ren_if.o_rw_phys,
               ren_if.o_old_rw_phys, ren_if.o_free_count, ren_if.o_free_overflow);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
